// File: rtl/cluster_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : cluster_ctrl_seq
// Purpose  : Power / clock / reset / boot sequencer for the cluster interface.
//            Power-up raises power, then clock enable, then releases reset,
//            then enables fetch. Power-down first waits for the cluster to go
//            idle (or times out), then asserts reset and removes clock and
//            power. Every phase is timed by one shared down-counter.
// Ports    : clk_i, rst_ni             clock, async active-low reset
//            req_valid_i/req_on_i      request handshake (1 = up, 0 = down)
//            req_boot_addr_i           boot address taken on power-up accept
//            req_ready_o               high in OFF and ON only
//            done_o                    one-cycle completion pulse
//            timeout_o                 sticky: last drain ended by timeout
//            cluster_busy_i            cluster busy (clk_i domain)
//            cluster_*_o               registered cluster control pins
//            status_on_o               high in state ON
// Revision : 1.0 - initial release
// ============================================================================
module cluster_ctrl_seq #(
    parameter int PWR_SETTLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT     = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_on_i,
    input  logic [63:0] req_boot_addr_i,
    output logic        req_ready_o,
    output logic        done_o,
    output logic        timeout_o,
    input  logic        cluster_busy_i,
    output logic        cluster_pow_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        status_on_o
);

    localparam int c_max_pr = (PWR_SETTLE_CYCLES > RST_HOLD_CYCLES) ? PWR_SETTLE_CYCLES
                                                                     : RST_HOLD_CYCLES;
    localparam int c_max    = (c_max_pr > DRAIN_TIMEOUT) ? c_max_pr : DRAIN_TIMEOUT;
    localparam int c_cnt_w  = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_pwr_load  = c_cnt_w'(PWR_SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rst_load  = c_cnt_w'(RST_HOLD_CYCLES - 1);
    // With the timeout disabled the counter is parked at 0 and never consulted.
    localparam logic [c_cnt_w-1:0] c_drain_load = (DRAIN_TIMEOUT > 0) ? c_cnt_w'(DRAIN_TIMEOUT - 1)
                                                                      : '0;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_CLK_ON = 3'd2,
        ST_BOOT   = 3'd3,
        ST_ON     = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_RST_DN = 3'd6,
        ST_PWR_DN = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_idle_seen;      // busy was sampled low last DRAIN cycle
    logic                 w_idle_seen_nxt;
    logic                 r_done_pend;      // completion seen, pin pulses next cycle
    logic                 w_done_evt;
    logic                 w_timeout_evt;
    logic                 w_clr_timeout;
    logic                 w_latch_addr;
    logic                 w_ready;
    logic                 w_accept;

    logic                 r_pow;
    logic                 r_clk_en;
    logic                 r_rstn;
    logic                 r_fetch;
    logic                 r_done;
    logic                 r_timeout;
    logic [63:0]          r_boot_addr;

    assign w_ready  = (r_state == ST_OFF) || (r_state == ST_ON);
    assign w_accept = req_valid_i && w_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_idle_seen <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idle_seen <= w_idle_seen_nxt;
            r_done_pend <= w_done_evt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        // Saturating decrement: the counter never wraps below zero.
        w_cnt_nxt       = (r_cnt != '0) ? (r_cnt - c_cnt_one) : r_cnt;
        w_idle_seen_nxt = 1'b0;
        w_done_evt      = 1'b0;
        w_timeout_evt   = 1'b0;
        w_clr_timeout   = 1'b0;
        w_latch_addr    = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_accept) begin
                    if (req_on_i) begin
                        w_state_nxt   = ST_PWR_UP;
                        w_cnt_nxt     = c_pwr_load;
                        w_latch_addr  = 1'b1;
                        w_clr_timeout = 1'b1;
                    end else begin
                        w_done_evt    = 1'b1;
                    end
                end
            end
            ST_PWR_UP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CLK_ON;
                    w_cnt_nxt   = c_rst_load;
                end
            end
            ST_CLK_ON: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_BOOT;
                end
            end
            ST_BOOT: begin
                w_state_nxt = ST_ON;
                w_done_evt  = 1'b1;
            end
            ST_ON: begin
                if (w_accept) begin
                    if (req_on_i) begin
                        w_done_evt    = 1'b1;
                    end else begin
                        w_state_nxt   = ST_DRAIN;
                        w_cnt_nxt     = c_drain_load;
                        w_clr_timeout = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                w_idle_seen_nxt = !cluster_busy_i;
                // A genuine idle exit takes precedence over a coincident timeout.
                if (!cluster_busy_i && r_idle_seen) begin
                    w_state_nxt = ST_RST_DN;
                    w_cnt_nxt   = c_rst_load;
                end else if ((DRAIN_TIMEOUT != 0) && (r_cnt == '0)) begin
                    w_state_nxt   = ST_RST_DN;
                    w_cnt_nxt     = c_rst_load;
                    w_timeout_evt = 1'b1;
                end
            end
            ST_RST_DN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PWR_DN;
                    w_cnt_nxt   = c_pwr_load;
                end
            end
            ST_PWR_DN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                    w_done_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Cluster pins are registered decodes of the current state, so each pin
    // changes one cycle after the state that owns it is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pow       <= 1'b0;
            r_clk_en    <= 1'b0;
            r_rstn      <= 1'b0;
            r_fetch     <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_boot_addr <= '0;
        end else begin
            r_pow    <= r_state inside {ST_PWR_UP, ST_CLK_ON, ST_BOOT, ST_ON, ST_DRAIN, ST_RST_DN};
            r_clk_en <= r_state inside {ST_CLK_ON, ST_BOOT, ST_ON, ST_DRAIN, ST_RST_DN};
            r_rstn   <= r_state inside {ST_BOOT, ST_ON, ST_DRAIN};
            r_fetch  <= (r_state == ST_ON);
            r_done   <= r_done_pend;
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if (w_clr_timeout) begin
                r_timeout <= 1'b0;
            end
            if (w_latch_addr) begin
                r_boot_addr <= req_boot_addr_i;
            end
        end
    end

    assign req_ready_o            = w_ready;
    assign status_on_o            = (r_state == ST_ON);
    assign done_o                 = r_done;
    assign timeout_o              = r_timeout;
    assign cluster_pow_o          = r_pow;
    assign cluster_clk_en_o       = r_clk_en;
    assign cluster_rstn_o         = r_rstn;
    assign cluster_fetch_enable_o = r_fetch;
    assign cluster_boot_addr_o    = r_boot_addr;

endmodule
`default_nettype wire

// File: tb/tb_cluster_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_ctrl_seq
// Purpose  : Self-checking bench for cluster_ctrl_seq. Instance a uses the
//            default drain timeout, instance b a short one (32 cycles).
//            Expected pin values per cycle come from closed-form timing
//            formulas measured from the accepting clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_ctrl_seq;

    localparam int P      = 16;
    localparam int R      = 8;
    localparam int DT_A   = 1024;
    localparam int DT_B   = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid_a, req_on_a, busy_a;
    logic [63:0] req_addr_a;
    logic        ready_a, done_a, to_a, pow_a, clken_a, rstn_a, fetch_a, son_a;
    logic [63:0] boot_a;

    logic        req_valid_b, req_on_b, busy_b;
    logic [63:0] req_addr_b;
    logic        ready_b, done_b, to_b, pow_b, clken_b, rstn_b, fetch_b, son_b;
    logic [63:0] boot_b;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] last_addr_a;

    cluster_ctrl_seq #(.PWR_SETTLE_CYCLES(P), .RST_HOLD_CYCLES(R), .DRAIN_TIMEOUT(DT_A)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_a), .req_on_i(req_on_a), .req_boot_addr_i(req_addr_a),
        .req_ready_o(ready_a), .done_o(done_a), .timeout_o(to_a),
        .cluster_busy_i(busy_a), .cluster_pow_o(pow_a), .cluster_clk_en_o(clken_a),
        .cluster_rstn_o(rstn_a), .cluster_fetch_enable_o(fetch_a),
        .cluster_boot_addr_o(boot_a), .status_on_o(son_a)
    );

    cluster_ctrl_seq #(.PWR_SETTLE_CYCLES(P), .RST_HOLD_CYCLES(R), .DRAIN_TIMEOUT(DT_B)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_b), .req_on_i(req_on_b), .req_boot_addr_i(req_addr_b),
        .req_ready_o(ready_b), .done_o(done_b), .timeout_o(to_b),
        .cluster_busy_i(busy_b), .cluster_pow_o(pow_b), .cluster_clk_en_o(clken_b),
        .cluster_rstn_o(rstn_b), .cluster_fetch_enable_o(fetch_b),
        .cluster_boot_addr_o(boot_b), .status_on_o(son_b)
    );

    // Observed vector: {ready, done, timeout, pow, clk_en, rstn, fetch, status_on}
    function automatic logic [7:0] obs_vec(input bit sel);
        if (sel) return {ready_b, done_b, to_b, pow_b, clken_b, rstn_b, fetch_b, son_b};
        return {ready_a, done_a, to_a, pow_a, clken_a, rstn_a, fetch_a, son_a};
    endfunction

    function automatic logic [63:0] boot_of(input bit sel);
        return sel ? boot_b : boot_a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic on, input logic [63:0] addr);
        if (sel) begin req_valid_b = v; req_on_b = on; req_addr_b = addr; end
        else     begin req_valid_a = v; req_on_a = on; req_addr_a = addr; end
    endtask

    task automatic set_busy(input bit sel, input logic b);
        if (sel) busy_b = b; else busy_a = b;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Power-up timeline, k = cycles after the accepting edge.
    function automatic logic [7:0] up_exp(input int k);
        return {k >= P+R+1, k == P+R+2, 1'b0, k >= 1, k >= P+1, k >= P+R+1, k >= P+R+2, k >= P+R+1};
    endfunction

    task automatic power_up(input bit sel, input logic [63:0] addr, input string tag);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, addr);
        @(posedge clk);
        for (int k = 0; k <= P+R+3; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 1'b0, 1'b0, rnd64());
            check($sformatf("%s up k=%0d", tag, k), obs_vec(sel), up_exp(k));
        end
        check($sformatf("%s boot", tag), boot_of(sel), addr);
    endtask

    // Power-down timeline; busy is high in cycles k < b and low from k = b on.
    // Idle needs low samples on two consecutive edges, i.e. after cycle b+1;
    // otherwise the drain ends after dt cycles with the timeout flag.
    task automatic power_down(input bit sel, input int b, input bit held, input bit first_done,
                              input string tag);
        int   dt;
        int   d;
        logic to_exp;
        dt = sel ? DT_B : DT_A;
        if (b + 1 <= dt - 1) begin d = b + 2; to_exp = 1'b0; end
        else                 begin d = dt;    to_exp = 1'b1; end
        if (!held) begin
            @(negedge clk);
            drive(sel, 1'b1, 1'b0, rnd64());
        end
        set_busy(sel, b > 0);
        @(posedge clk);
        for (int k = 0; k <= d+R+P+2; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 1'b0, 1'b0, rnd64());
            check($sformatf("%s down k=%0d", tag, k), obs_vec(sel),
                  {k >= d+R+P, (k == d+R+P+1) || (first_done && k == 0),
                   (k >= d) ? to_exp : 1'b0,
                   k < d+R+1, k < d+R+1, k < d+1, k == 0, 1'b0});
            set_busy(sel, k < b);
        end
        set_busy(sel, 1'b0);
    endtask

    task automatic noop(input bit sel, input logic on, input logic [63:0] addr,
                        input logic [7:0] base, input logic [63:0] exp_boot, input string tag);
        @(negedge clk);
        drive(sel, 1'b1, on, addr);
        @(posedge clk);
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 1'b0, 1'b0, rnd64());
            check($sformatf("%s noop k=%0d", tag, k), obs_vec(sel),
                  base | ((k == 1) ? 8'b0100_0000 : 8'b0));
        end
        check($sformatf("%s noop boot", tag), boot_of(sel), exp_boot);
    endtask

    localparam logic [7:0] c_off_vec = 8'b1000_0000;
    localparam logic [7:0] c_on_vec  = 8'b1001_1111;

    initial begin
        logic [63:0] addr;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0); set_busy(1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'h0); set_busy(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("reset a", obs_vec(1'b0), c_off_vec);
        check("reset b", obs_vec(1'b1), c_off_vec);
        check("reset boot a", boot_a, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset a", obs_vec(1'b0), c_off_vec);

        // Directed power-up / power-down (busy first seen low at edge 40).
        last_addr_a = 64'h1C00_8080;
        power_up(1'b0, last_addr_a, "dir");
        power_down(1'b0, 39, 1'b0, 1'b0, "dir busy");
        noop(1'b0, 1'b0, rnd64(), c_off_vec, last_addr_a, "off");

        // Drain timeout on instance b; flag stays until the next power-up.
        power_up(1'b1, rnd64(), "b");
        power_down(1'b1, 1000, 1'b0, 1'b0, "b stuck");
        repeat (5) @(negedge clk);
        check("b timeout sticky", obs_vec(1'b1), 8'b1010_0000);
        power_up(1'b1, rnd64(), "b clr");
        power_down(1'b1, 29, 1'b0, 1'b0, "b late idle");

        // Randomized cycles on instance a.
        for (int it = 0; it < 3; it++) begin
            last_addr_a = rnd64();
            power_up(1'b0, last_addr_a, $sformatf("r%0d", it));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            noop(1'b0, 1'b1, rnd64(), c_on_vec, last_addr_a, $sformatf("r%0d on", it));
            power_down(1'b0, $urandom_range(0, 45), 1'b0, 1'b0, $sformatf("r%0d", it));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Power-down held from cycle 5 of a power-up: accepted on first ON cycle.
        last_addr_a = rnd64();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, last_addr_a);
        @(posedge clk);
        for (int k = 0; k <= P+R+1; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 1'b0, 1'b0, rnd64());
            check($sformatf("held up k=%0d", k), obs_vec(1'b0), up_exp(k));
            if (k >= 4) drive(1'b0, 1'b1, 1'b0, rnd64());
        end
        check("held boot", boot_a, last_addr_a);
        power_down(1'b0, $urandom_range(0, 5), 1'b1, 1'b1, "held");

        // Asynchronous reset in cycle 20 of a power-up, then a full replay.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, rnd64());
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 1'b0, 1'b0, rnd64());
            check($sformatf("pre-rst k=%0d", k), obs_vec(1'b0), up_exp(k));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst a", obs_vec(1'b0), c_off_vec);
        check("async rst boot", boot_a, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        addr = rnd64();
        power_up(1'b0, addr, "replay");
        power_down(1'b0, $urandom_range(0, 10), 1'b0, 1'b0, "replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
